// File: rtl/aes_uart_seq.sv
// Sequencer for the AES-encrypt -> UART -> AES-decrypt loopback datapath.
// Latches one block and key, waits for AES settling, runs the UART transfer and returns the result.
module aes_uart_seq #(
   parameter int unsigned SETTLE_CYC  = 4,
   parameter int unsigned TIMEOUT_CYC = 200000,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [127:0]     req_data,
   input  logic [127:0]     req_key,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [127:0]     resp_data,
   output logic             resp_err,
   output logic             busy,
   output logic [CNT_W-1:0] blk_cnt,
   output logic [127:0]     dp_data_in,
   output logic [127:0]     dp_key,
   output logic             dp_en_tx,
   output logic             dp_en_rx,
   input  logic             dp_tx_done,
   input  logic             dp_rx_done,
   input  logic [127:0]     dp_data_out
);

   localparam int unsigned    TO_W        = $clog2(TIMEOUT_CYC);
   localparam logic [7:0]     SETTLE_LOAD = 8'(SETTLE_CYC - 1);
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {StIdle, StSettle, StXfer, StResp} state_e;

   state_e          state;
   logic [7:0]      settle_cnt;
   logic [TO_W-1:0] to_cnt;
   logic            tx_seen, rx_seen;
   logic            tx_now, rx_now;

   // A done sampled this cycle counts together with the sticky flag.
   assign tx_now = tx_seen | dp_tx_done;
   assign rx_now = rx_seen | dp_rx_done;

   assign req_ready  = (state == StIdle);
   assign resp_valid = (state == StResp);
   assign busy       = (state != StIdle);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= StIdle;
         settle_cnt <= '0;
         to_cnt     <= '0;
         tx_seen    <= 1'b0;
         rx_seen    <= 1'b0;
         dp_data_in <= '0;
         dp_key     <= '0;
         dp_en_tx   <= 1'b0;
         dp_en_rx   <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         blk_cnt    <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (req_valid) begin
                  dp_data_in <= req_data;
                  dp_key     <= req_key;
                  settle_cnt <= SETTLE_LOAD;
                  state      <= StSettle;
               end
            end
            StSettle: begin
               if (settle_cnt == 8'd0) begin
                  to_cnt   <= '0;
                  tx_seen  <= 1'b0;
                  rx_seen  <= 1'b0;
                  dp_en_tx <= 1'b1;
                  dp_en_rx <= 1'b1;
                  state    <= StXfer;
               end else begin
                  settle_cnt <= settle_cnt - 8'd1;
               end
            end
            StXfer: begin
               // Completion takes priority over a coincident timeout.
               if (tx_now && rx_now) begin
                  resp_data <= dp_data_out;
                  resp_err  <= 1'b0;
                  dp_en_tx  <= 1'b0;
                  dp_en_rx  <= 1'b0;
                  state     <= StResp;
               end else if (to_cnt == TO_LAST) begin
                  resp_data <= '0;
                  resp_err  <= 1'b1;
                  dp_en_tx  <= 1'b0;
                  dp_en_rx  <= 1'b0;
                  state     <= StResp;
               end else begin
                  to_cnt   <= to_cnt + 1'b1;
                  tx_seen  <= tx_now;
                  rx_seen  <= rx_now;
                  dp_en_tx <= ~tx_now;
               end
            end
            StResp: begin
               if (resp_ready) begin
                  if (!resp_err) blk_cnt <= blk_cnt + 1'b1;
                  tx_seen <= 1'b0;
                  rx_seen <= 1'b0;
                  state   <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_uart_seq.sv
// Self-checking bench for aes_uart_seq with a loopback datapath model and a cycle-level reference.
module tb_aes_uart_seq;

   localparam int unsigned S  = 4;
   localparam int unsigned TO = 50;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [127:0]  req_data = '0;
   logic [127:0]  req_key = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [127:0]  resp_data;
   logic          resp_err;
   logic          busy;
   logic [CW-1:0] blk_cnt;
   logic [127:0]  dp_data_in;
   logic [127:0]  dp_key;
   logic          dp_en_tx;
   logic          dp_en_rx;
   logic          dp_tx_done = 1'b0;
   logic          dp_rx_done = 1'b0;
   logic [127:0]  dp_data_out = '0;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_cnt = 0;

   aes_uart_seq #(
      .SETTLE_CYC (S),
      .TIMEOUT_CYC(TO),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_key    (req_key),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy),
      .blk_cnt    (blk_cnt),
      .dp_data_in (dp_data_in),
      .dp_key     (dp_key),
      .dp_en_tx   (dp_en_tx),
      .dp_en_rx   (dp_en_rx),
      .dp_tx_done (dp_tx_done),
      .dp_rx_done (dp_rx_done),
      .dp_data_out(dp_data_out)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_values(input string tag);
      n_tests++;
      if ({req_ready, resp_valid, busy, dp_en_tx, dp_en_rx, resp_err} !== 6'b100000) begin
         n_fail++;
         $display("FAIL %s_ctrl: got rdy/vld/busy/tx/rx/err=%b want 100000", tag,
                  {req_ready, resp_valid, busy, dp_en_tx, dp_en_rx, resp_err});
      end
      n_tests++;
      if ({dp_data_in, dp_key, resp_data} !== '0 || blk_cnt !== '0) begin
         n_fail++;
         $display("FAIL %s_data: got in=%h key=%h resp=%h cnt=%0d want all zero", tag,
                  dp_data_in, dp_key, resp_data, blk_cnt);
      end
   endtask

   task automatic do_req(input logic [127:0] d, input logic [127:0] k);
      req_data  = d;
      req_key   = k;
      req_valid = 1'b1;
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL req_ready_idle: got %b want 1", req_ready);
      end
      step();
      req_valid = 1'b0;
      req_data  = rnd128();
      req_key   = rnd128();
      n_tests++;
      if (busy !== 1'b1 || req_ready !== 1'b0 || dp_data_in !== d || dp_key !== k) begin
         n_fail++;
         $display("FAIL accept: got busy=%b rdy=%b in=%h key=%h want 1 0 %h %h",
                  busy, req_ready, dp_data_in, dp_key, d, k);
      end
   endtask

   // Reference: enables rise S edges after accept; tx enable falls the cycle after tx done;
   // the edge sampling the later done captures data and raises resp_valid.
   task automatic do_xfer(input logic [127:0] d, input int tx_at, input int rx_at,
                          input bit pulse, input bit early);
      int last;
      int j;
      bit etx, erx, evld;
      last = (tx_at > rx_at) ? tx_at : rx_at;
      for (int cyc = 0; cyc <= S + last + 1; cyc++) begin
         j = cyc - S;
         if (j < 0) begin
            dp_tx_done = early;
            dp_rx_done = early;
         end else if (pulse) begin
            dp_tx_done = (j == tx_at);
            dp_rx_done = (j == rx_at);
         end else begin
            dp_tx_done = (j >= tx_at) && (j <= last);
            dp_rx_done = (j >= rx_at) && (j <= last);
         end
         dp_data_out = (j == last) ? d : rnd128();
         evld = (j == last + 1);
         erx  = (j >= 0) && (j <= last);
         etx  = (j >= 0) && (j <= tx_at) && (j <= last);
         n_tests++;
         if (dp_en_tx !== etx || dp_en_rx !== erx || resp_valid !== evld) begin
            n_fail++;
            $display("FAIL xfer_cyc%0d: got tx=%b rx=%b vld=%b want %b %b %b",
                     cyc, dp_en_tx, dp_en_rx, resp_valid, etx, erx, evld);
         end
         if (cyc < S + last + 1) step();
      end
      n_tests++;
      if (resp_data !== d || resp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL xfer_resp: got data=%h err=%b want %h 0", resp_data, resp_err, d);
      end
   endtask

   task automatic do_resp(input int hold, input logic [127:0] ed, input logic [127:0] ein,
                          input bit err);
      for (int i = 0; i < hold; i++) begin
         req_valid = i[0];
         req_data  = rnd128();
         n_tests++;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== ed ||
             resp_err !== err || dp_data_in !== ein) begin
            n_fail++;
            $display("FAIL hold%0d: got vld=%b rdy=%b data=%h err=%b in=%h want 1 0 %h %b %h",
                     i, resp_valid, req_ready, resp_data, resp_err, dp_data_in, ed, err, ein);
         end
         step();
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      if (!err) exp_cnt = (exp_cnt + 1) % (1 << CW);
      n_tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || blk_cnt !== exp_cnt[CW-1:0]) begin
         n_fail++;
         $display("FAIL handshake: got vld=%b rdy=%b busy=%b cnt=%0d want 0 1 0 %0d",
                  resp_valid, req_ready, busy, blk_cnt, exp_cnt);
      end
   endtask

   task automatic run_block(input int tx_at, input int rx_at, input bit pulse, input bit early);
      logic [127:0] d;
      d = rnd128();
      do_req(d, rnd128());
      do_xfer(d, tx_at, rx_at, pulse, early);
      do_resp($urandom_range(0, 2), d, d, 1'b0);
   endtask

   task automatic test_reset();
      #12;
      test_reset_values("reset");
      reset = 1'b1;
      step();
   endtask

   task automatic test_nominal();
      logic [127:0] pt;
      pt = 128'h00112233445566778899aabbccddeeff;
      do_req(pt, 128'h000102030405060708090a0b0c0d0e0f);
      do_xfer(pt, 5, 7, 1'b0, 1'b0);
      do_resp(0, pt, pt, 1'b0);
      n_tests++;
      if (blk_cnt !== 2'd1) begin
         n_fail++;
         $display("FAIL nominal_cnt: got %0d want 1", blk_cnt);
      end
   endtask

   task automatic test_done_order();
      run_block(5, 2, 1'b1, 1'b0);
      run_block(4, 4, 1'b1, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 3; i++)
         run_block($urandom_range(0, 10), $urandom_range(0, 10), 1'($urandom), 1'($urandom));
   endtask

   task automatic test_timeout();
      logic [127:0] d;
      int j;
      bit evld;
      d = rnd128();
      do_req(d, rnd128());
      for (int cyc = 0; cyc <= S + TO; cyc++) begin
         j = cyc - S;
         dp_tx_done  = (j == 3);
         dp_rx_done  = 1'b0;
         dp_data_out = rnd128();
         evld = (j == TO);
         n_tests++;
         if (resp_valid !== evld || dp_en_rx !== (j >= 0 && j < TO) ||
             dp_en_tx !== (j >= 0 && j <= 3)) begin
            n_fail++;
            $display("FAIL timeout_cyc%0d: got vld=%b tx=%b rx=%b want vld=%b",
                     cyc, resp_valid, dp_en_tx, dp_en_rx, evld);
         end
         if (cyc < S + TO) step();
      end
      dp_tx_done = 1'b0;
      n_tests++;
      if (resp_err !== 1'b1 || resp_data !== '0) begin
         n_fail++;
         $display("FAIL timeout_resp: got err=%b data=%h want 1 0", resp_err, resp_data);
      end
      do_resp(2, '0, d, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [127:0] d;
      d = rnd128();
      do_req(d, rnd128());
      do_xfer(d, 1, 3, 1'b0, 1'b0);
      do_resp(10, d, d, 1'b0);
      run_block(2, 2, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [127:0] d;
      d = rnd128();
      do_req(d, rnd128());
      for (int i = 0; i < S + 2; i++) step();
      n_tests++;
      if (dp_en_rx !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_in_xfer: got rx=%b want 1", dp_en_rx);
      end
      #3;
      reset = 1'b0;
      #1;
      exp_cnt = 0;
      test_reset_values("reset_mid");
      #2;
      reset = 1'b1;
      step();
      run_block(3, 1, 1'b1, 1'b0);
   endtask

   task automatic test_wrap();
      int seq[5];
      seq = '{1, 2, 3, 0, 1};
      #3;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      exp_cnt = 0;
      step();
      for (int i = 0; i < 5; i++) begin
         run_block($urandom_range(0, 4), $urandom_range(0, 4), 1'b1, 1'b0);
         n_tests++;
         if (blk_cnt !== seq[i][CW-1:0]) begin
            n_fail++;
            $display("FAIL wrap%0d: got %0d want %0d", i, blk_cnt, seq[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_done_order();
      test_random();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
